// File: rtl/fifo_tx_drain.sv
// FIFO read-side drain: pops one word at a time and shifts it out as an async
// serial frame (start, DW data bits LSB-first, [parity], stop). Define TX_PARITY_EN for the even-parity bit.
module fifo_tx_drain #(
  parameter int DW           = 3,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic          rclk,
  input  logic          rst,
  input  logic          en,
  input  logic          empy,
  input  logic [DW-1:0] datout,
  output logic          rd,
  output logic          txd,
  output logic          busy,
  output logic          done
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = $clog2(DW) + 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LATCH,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic          txd_q, txd_d;
  logic          baud_last;
`ifdef TX_PARITY_EN
  logic          par_q, par_d;
`endif

  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      txd_q   <= 1'b1;
`ifdef TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      txd_q   <= txd_d;
`ifdef TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // txd_d is the line level for the state being entered, so txd stays registered.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    txd_d     = txd_q;
`ifdef TX_PARITY_EN
    par_d     = par_q;
`endif
    baud_last = (baud_q == BAUD_LAST);
    case (state_q)
      S_IDLE: begin
        txd_d  = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        if (en && !empy) state_d = S_POP;
      end
      S_POP: state_d = S_LATCH;
      S_LATCH: begin
        shreg_d = datout;
`ifdef TX_PARITY_EN
        par_d   = ^datout;
`endif
        txd_d   = 1'b0;
        baud_d  = '0;
        state_d = S_START;
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          txd_d   = shreg_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
`ifdef TX_PARITY_EN
            txd_d   = par_q;
            state_d = S_PARITY;
`else
            txd_d   = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
            txd_d = shreg_d[0];
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
`ifdef TX_PARITY_EN
      S_PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          txd_d   = 1'b1;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = (en && !empy) ? S_POP : S_IDLE;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  assign rd   = (state_q == S_POP);
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_STOP) && baud_last;
  assign txd  = txd_q;

endmodule

// File: tb/tb_fifo_tx_drain.sv
// Bench for fifo_tx_drain: FIFO model, serial-frame decoder, vector table,
// corner-case sequences and randomized traffic.
module tb_fifo_tx_drain;

  localparam int DW  = 3;
  localparam int CPB = 4;
`ifdef TX_PARITY_EN
  localparam int NB = DW + 3;
`else
  localparam int NB = DW + 2;
`endif
  localparam int FRAME = NB * CPB;

  logic          rclk = 1'b0;
  logic          rst  = 1'b1;
  logic          en   = 1'b0;
  logic          empy = 1'b1;
  logic [DW-1:0] datout = '0;
  logic          rd, txd, busy, done;

  fifo_tx_drain #(.DW(DW), .CLKS_PER_BIT(CPB)) dut (
    .rclk   (rclk),
    .rst    (rst),
    .en     (en),
    .empy   (empy),
    .datout (datout),
    .rd     (rd),
    .txd    (txd),
    .busy   (busy),
    .done   (done)
  );

  initial forever #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_count = 0;
  int pops = 0;
  int frames = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  bit            rx_active = 0;
  int            rx_t0 = 0;
  logic [DW-1:0] rx_word = '0;

  typedef struct {
    logic [DW-1:0] word;
    logic          en;
    logic          exp_pop;
    logic [4:0]    exp_ser;  // start, d0, d1, d2, stop as seen on txd
    logic          exp_par;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    empy = 1'b0;
  endtask

  task automatic flush_fifo();
    fifo_q.delete();
    empy = 1'b1;
  endtask

  // One clock: FIFO model reacts to rd, then the serial decoder inspects txd.
  task automatic step();
    logic rd_pre;
    int   off;
    rd_pre = rd;
    @(posedge rclk);
    #1;
    cyc++;
    if (rd_pre === 1'b1) begin
      chk("rd_when_nonempty", 32'(fifo_q.size() > 0), 32'(1));
      if (fifo_q.size() > 0) begin
        datout = fifo_q.pop_front();
        exp_q.push_back(datout);
        pops++;
      end
    end
    empy = (fifo_q.size() == 0);
    if (rd === 1'b1) begin
      rd_count++;
      chk("rd_one_cycle", 32'(rd_pre), 32'(0));
      chk("busy_in_pop", 32'(busy), 32'(1));
    end
    if (!rx_active && txd === 1'b0) begin
      rx_active = 1;
      rx_t0     = cyc;
      rx_word   = '0;
    end
    if (rx_active) begin
      off = cyc - rx_t0;
      chk("busy_in_frame", 32'(busy), 32'(1));
      chk("done_pulse", 32'(done), 32'(off == FRAME - 1));
      if (off == CPB / 2) chk("start_bit", 32'(txd), 32'(0));
      for (int i = 0; i < DW; i++)
        if (off == CPB * (1 + i) + CPB / 2) rx_word[i] = txd;
`ifdef TX_PARITY_EN
      if (off == CPB * (1 + DW) + CPB / 2 && exp_q.size() > 0)
        chk("parity_bit", 32'(txd), 32'(^exp_q[0]));
`endif
      if (off == FRAME - CPB + CPB / 2) chk("stop_bit", 32'(txd), 32'(1));
      if (off == FRAME - 1) begin
        chk("frame_has_pop", 32'(exp_q.size() > 0), 32'(1));
        if (exp_q.size() > 0) chk("rx_word", 32'(rx_word), 32'(exp_q.pop_front()));
        frames++;
        rx_active = 0;
      end
    end else begin
      chk("done_outside_frame", 32'(done), 32'(0));
    end
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic wait_rd(input int max, output bit found);
    found = 0;
    for (int i = 0; i < max && !found; i++) begin
      step();
      if (rd === 1'b1) found = 1;
    end
    if (!found) chk("rd_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while ((busy !== 1'b0 || rx_active) && n < max) begin
      step();
      n++;
    end
    if (n >= max) chk("idle_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    bit   found;
    int   t, r0, f0, p0, bcnt, exp_bit;
    vecs[0] = '{3'd6, 1'b1, 1'b1, 5'b11100, 1'b0};
    vecs[1] = '{3'd2, 1'b1, 1'b1, 5'b10100, 1'b1};
    vecs[2] = '{3'd4, 1'b1, 1'b1, 5'b11000, 1'b1};
    vecs[3] = '{3'd7, 1'b1, 1'b1, 5'b11110, 1'b1};
    vecs[4] = '{3'd0, 1'b1, 1'b1, 5'b10000, 1'b0};
    vecs[5] = '{3'd5, 1'b1, 1'b1, 5'b11010, 1'b0};
    vecs[6] = '{3'd3, 1'b0, 1'b0, 5'b10110, 1'b0};

    // Reset state, checked mid-cycle while rst is low
    #1 rst = 1'b0;
    en = 1'b1;
    #1;
    chk("reset_txd", 32'(txd), 32'(1));
    chk("reset_rd", 32'(rd), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    en = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();

    // Table of single-word frames
    foreach (vecs[k]) begin
      en = vecs[k].en;
      push(vecs[k].word);
      r0 = rd_count;
      if (vecs[k].exp_pop) begin
        wait_rd(10, found);
        if (found) begin
          t = cyc;
          step_to(t + 1);
          chk("txd_high_in_latch", 32'(txd), 32'(1));
          step_to(t + 2);
          chk("txd_fall_latency", 32'(txd), 32'(0));
          for (int b = 0; b < NB; b++) begin
            step_to(t + 2 + b * CPB + CPB / 2);
            if (b <= DW) exp_bit = int'(vecs[k].exp_ser[b]);
            else if (b == NB - 1) exp_bit = int'(vecs[k].exp_ser[4]);
            else exp_bit = int'(vecs[k].exp_par);
            chk("vec_txd_bit", 32'(txd), 32'(exp_bit));
          end
          step_to(t + 2 + FRAME - 1);
          chk("vec_done_last_stop", 32'(done), 32'(1));
          wait_idle(20);
          chk("vec_one_rd", 32'(rd_count - r0), 32'(1));
        end
      end else begin
        repeat (12) step();
        chk("vec_no_rd", 32'(rd_count - r0), 32'(0));
        chk("vec_txd_idle", 32'(txd), 32'(1));
        flush_fifo();
      end
    end

    // Back-to-back: three words, busy continuous through all frames
    en = 1'b1;
    r0 = rd_count;
    f0 = frames;
    push(3'd2); push(3'd6); push(3'd4);
    bcnt = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (busy === 1'b1) bcnt++;
      if (bcnt > 0 && busy !== 1'b1) break;
    end
    wait_idle(20);
    chk("b2b_rd_pulses", 32'(rd_count - r0), 32'(3));
    chk("b2b_frames", 32'(frames - f0), 32'(3));
    chk("b2b_busy_cycles", 32'(bcnt), 32'(3 * (FRAME + 2)));

    // Empty with enable, then data with enable low
    r0 = rd_count;
    en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("empty_rd", 32'(rd), 32'(0));
      chk("empty_txd", 32'(txd), 32'(1));
    end
    en = 1'b0;
    push(3'd3);
    for (int i = 0; i < 50; i++) begin
      step();
      chk("disabled_rd", 32'(rd), 32'(0));
      chk("disabled_txd", 32'(txd), 32'(1));
    end
    chk("quiet_rd_count", 32'(rd_count - r0), 32'(0));
    flush_fifo();

    // en dropped during a data bit: frame finishes, no further pop
    en = 1'b1;
    f0 = frames;
    push(3'd7); push(3'd5);
    wait_rd(10, found);
    t = cyc;
    r0 = rd_count;
    step_to(t + 2 + CPB + 1);
    en = 1'b0;
    repeat (60) step();
    chk("endrop_no_rd", 32'(rd_count - r0), 32'(0));
    chk("endrop_frame_done", 32'(frames - f0), 32'(1));
    chk("endrop_word_left", 32'(fifo_q.size()), 32'(1));
    flush_fifo();

    // Reset in the middle of a data bit
    en = 1'b1;
    push(3'd5);
    wait_rd(10, found);
    t = cyc;
    step_to(t + 2 + CPB + 2);
    #2 rst = 1'b0;
    #1;
    chk("midreset_txd", 32'(txd), 32'(1));
    chk("midreset_busy", 32'(busy), 32'(0));
    chk("midreset_rd", 32'(rd), 32'(0));
    rx_active = 0;
    exp_q.delete();
    repeat (2) step();
    rst = 1'b1;
    r0 = rd_count;
    repeat (10) step();
    chk("postreset_no_rd", 32'(rd_count - r0), 32'(0));
    f0 = frames;
    push(3'd3);
    wait_rd(10, found);
    wait_idle(FRAME + 10);
    chk("postreset_fresh_pop", 32'(rd_count - r0), 32'(1));
    chk("postreset_frame", 32'(frames - f0), 32'(1));

    // Randomized traffic with en toggling at arbitrary points
    p0 = pops;
    f0 = frames;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0 && fifo_q.size() < 6) push(DW'($urandom_range(0, 7)));
      if ($urandom_range(0, 19) == 0) en = ~en;
      step();
    end
    en = 1'b1;
    for (int i = 0; i < 2000 && (fifo_q.size() > 0 || busy === 1'b1 || rx_active); i++) step();
    chk("rand_drained", 32'(fifo_q.size()), 32'(0));
    chk("rand_idle", 32'(busy), 32'(0));
    chk("rand_no_pending", 32'(exp_q.size()), 32'(0));
    chk("rand_frames_eq_pops", 32'(frames - f0), 32'(pops - p0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
